// File: rtl/sys_ctrl.sv
// sys_ctrl: byte-stream command decoder that sits between a UART and a
// register file.
//   0xAA <addr> <data> -> register write (rf_wr_en pulse)
//   0xBB <addr>        -> register read (rf_rd_en pulse); the returned data
//                         is sent back through the transmitter (tx_valid pulse)
// Any other command byte, a byte flagged with rx_err, or a byte that arrives
// while a read is being serviced produces a one-cycle cmd_err pulse.
//
// Optional feature: define SYS_CTRL_TIMEOUT_EN to abort a partial command
// after TIMEOUT idle cycles. Without the macro the block waits indefinitely
// and TIMEOUT is unused.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rx_data/rx_valid/rx_err      received byte stream
//   rf_addr/rf_wr_en/rf_wr_data  register-file write side
//   rf_rd_en/rf_rd_data/rf_rd_valid  register-file read side
//   tx_data/tx_valid/tx_busy     transmitter side
//   cmd_err                      one-cycle error pulse
//   busy                         high whenever not idle
module sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_err,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic                  rf_wr_en,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  rf_rd_en,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    input  logic                  rf_rd_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_busy,
    output logic                  cmd_err,
    output logic                  busy
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt, tdata_nxt;
    logic                  wr_nxt, rd_nxt, txv_nxt, err_nxt;
    logic                  abort;

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt, cnt_nxt;
    logic          progress;
`endif

    // A flagged byte aborts whatever is in flight, in every state, and wins
    // over a simultaneous rf_rd_valid.
    assign abort = rx_valid && rx_err;

    always_comb begin
        state_nxt = state;
        addr_nxt  = rf_addr;
        wdata_nxt = rf_wr_data;
        tdata_nxt = tx_data;
        wr_nxt    = 1'b0;
        rd_nxt    = 1'b0;
        txv_nxt   = 1'b0;
        err_nxt   = 1'b0;
`ifdef SYS_CTRL_TIMEOUT_EN
        progress  = 1'b0;
        cnt_nxt   = '0;
`endif
        if (abort) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end else begin
            case (state)
                IDLE: if (rx_valid) begin
                    if (rx_data == CMD_WR)      state_nxt = WR_ADDR;
                    else if (rx_data == CMD_RD) state_nxt = RD_ADDR;
                    else                        err_nxt   = 1'b1;
                end
                WR_ADDR: if (rx_valid) begin
                    addr_nxt  = rx_data[ADDR_WIDTH-1:0];
                    state_nxt = WR_DATA;
`ifdef SYS_CTRL_TIMEOUT_EN
                    progress  = 1'b1;
`endif
                end
                WR_DATA: if (rx_valid) begin
                    wdata_nxt = rx_data;
                    wr_nxt    = 1'b1;
                    state_nxt = IDLE;
`ifdef SYS_CTRL_TIMEOUT_EN
                    progress  = 1'b1;
`endif
                end
                RD_ADDR: if (rx_valid) begin
                    addr_nxt  = rx_data[ADDR_WIDTH-1:0];
                    rd_nxt    = 1'b1;
                    state_nxt = RD_WAIT;
`ifdef SYS_CTRL_TIMEOUT_EN
                    progress  = 1'b1;
`endif
                end
                RD_WAIT: begin
                    // Stray bytes are dropped; the read keeps going.
                    if (rx_valid) err_nxt = 1'b1;
                    if (rf_rd_valid) begin
                        tdata_nxt = rf_rd_data;
                        state_nxt = TX_SEND;
`ifdef SYS_CTRL_TIMEOUT_EN
                        progress  = 1'b1;
`endif
                    end
                end
                TX_SEND: begin
                    if (rx_valid) err_nxt = 1'b1;
                    if (!tx_busy) begin
                        txv_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
`ifdef SYS_CTRL_TIMEOUT_EN
        // Count only while stalled in a waiting state; any transition out of
        // these states involves progress or abort, so the count restarts at 0.
        if (!abort && !progress &&
            (state == WR_ADDR || state == WR_DATA ||
             state == RD_ADDR || state == RD_WAIT)) begin
            if (cnt == CW'(TIMEOUT - 1)) begin
                state_nxt = IDLE;
                err_nxt   = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rf_addr    <= '0;
            rf_wr_data <= '0;
            tx_data    <= '0;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            tx_valid   <= 1'b0;
            cmd_err    <= 1'b0;
            busy       <= 1'b0;
`ifdef SYS_CTRL_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            state      <= state_nxt;
            rf_addr    <= addr_nxt;
            rf_wr_data <= wdata_nxt;
            tx_data    <= tdata_nxt;
            rf_wr_en   <= wr_nxt;
            rf_rd_en   <= rd_nxt;
            tx_valid   <= txv_nxt;
            cmd_err    <= err_nxt;
            // Registered alongside state so busy tracks state != IDLE exactly.
            busy       <= (state_nxt != IDLE);
`ifdef SYS_CTRL_TIMEOUT_EN
            cnt        <= cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Self-checking bench for sys_ctrl: a command-level reference model predicts
// each output strobe and the cycle it appears in; a monitor compares what
// the DUT presents against that queue and checks busy every cycle.
module tb_sys_ctrl;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid, rx_err;
    logic [3:0] rf_addr;
    logic       rf_wr_en, rf_rd_en, rf_rd_valid, tx_valid, tx_busy, cmd_err, busy;
    logic [7:0] rf_wr_data, rf_rd_data, tx_data;

    sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
        .rf_rd_en(rf_rd_en), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
        .cmd_err(cmd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       wr, rd, tx, err;
        logic [3:0] addr;
        logic [7:0] wd, td;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0, fails = 0;
    int   cyc = 0;
    logic m_busy = 1'b0;
    logic mon_en = 1'b0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Works at command level: bytes of the current frame collect in a queue,
    // and a read in progress is tracked as "awaiting data" / "awaiting send".
    logic [7:0] frame[$];
    bit         rd_out = 0, tx_pend = 0;
    logic [7:0] tx_byte = 0;
    int         timer = 0;

    always @(posedge clk) begin
        ev_t e;
        bit  waiting, progress, aborted;
        cyc++;
        e = '{cyc: cyc, wr: 0, rd: 0, tx: 0, err: 0, addr: 0, wd: 0, td: 0};
        if (rst) begin
            frame.delete(); rd_out = 0; tx_pend = 0; timer = 0; m_busy = 0;
        end else begin
            waiting  = (frame.size() != 0) || rd_out;
            progress = 0;
            aborted  = 0;
            if (rx_valid && rx_err) begin
                e.err = 1; frame.delete(); rd_out = 0; tx_pend = 0; aborted = 1;
            end else if (rd_out || tx_pend) begin
                if (rx_valid) e.err = 1;
                if (tx_pend) begin
                    if (!tx_busy) begin e.tx = 1; e.td = tx_byte; tx_pend = 0; end
                end else if (rf_rd_valid) begin
                    tx_byte = rf_rd_data; tx_pend = 1; rd_out = 0; progress = 1;
                end
            end else if (rx_valid) begin
                progress = 1;
                frame.push_back(rx_data);
                if (frame[0] != 8'hAA && frame[0] != 8'hBB) begin
                    e.err = 1; frame.delete();
                end else if (frame[0] == 8'hAA && frame.size() == 3) begin
                    e.wr = 1; e.addr = frame[1][3:0]; e.wd = frame[2]; frame.delete();
                end else if (frame[0] == 8'hBB && frame.size() == 2) begin
                    e.rd = 1; e.addr = frame[1][3:0]; frame.delete(); rd_out = 1;
                end
            end
`ifdef SYS_CTRL_TIMEOUT_EN
            if (waiting && !progress && !aborted) begin
                timer++;
                if (timer == TO) begin
                    e.err = 1; frame.delete(); rd_out = 0; timer = 0;
                end
            end else timer = 0;
`else
            if (waiting && progress && aborted) timer = 0;
`endif
            m_busy = (frame.size() != 0) || rd_out || tx_pend;
            if (e.wr || e.rd || e.tx || e.err) exp_q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            check(busy == m_busy, "busy", busy, m_busy);
            if (rf_wr_en || rf_rd_en || tx_valid || cmd_err) begin
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_strobe", {rf_wr_en, rf_rd_en, tx_valid, cmd_err}, 0);
                end else begin
                    ev_t x;
                    x = exp_q.pop_front();
                    check(x.cyc == cyc, "strobe_cycle", cyc, x.cyc);
                    check({rf_wr_en, rf_rd_en, tx_valid, cmd_err} == {x.wr, x.rd, x.tx, x.err},
                          "strobe_kind", {rf_wr_en, rf_rd_en, tx_valid, cmd_err},
                          {x.wr, x.rd, x.tx, x.err});
                    if (x.wr || x.rd) check(rf_addr == x.addr, "rf_addr", rf_addr, x.addr);
                    if (x.wr) check(rf_wr_data == x.wd, "rf_wr_data", rf_wr_data, x.wd);
                    if (x.tx) check(tx_data == x.td, "tx_data", tx_data, x.td);
                end
            end
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                check(0, "missing_strobe", 0, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
        rx_valid = 0; rx_err = 0; rf_rd_valid = 0; rst = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic put(input logic [7:0] b, input logic e);
        rx_data = b; rx_valid = 1; rx_err = e; step();
    endtask

    initial begin
        rst = 1; rx_data = 0; rx_valid = 0; rx_err = 0;
        rf_rd_data = 0; rf_rd_valid = 0; tx_busy = 0;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        check({rf_addr, rf_wr_data, tx_data} == 0, "reset_data", {rf_addr, rf_wr_data, tx_data}, 0);
        check({rf_wr_en, rf_rd_en, tx_valid, cmd_err, busy} == 0, "reset_ctrl",
              {rf_wr_en, rf_rd_en, tx_valid, cmd_err, busy}, 0);
        #1; rst = 0; mon_en = 1;
        idle(2);

        // write 0x5C to register 3
        put(8'hAA, 0); put(8'h03, 0); put(8'h5C, 0); idle(2);
        @(negedge clk);
        check(busy == 0, "busy_after_write", busy, 0);
        check(rf_addr == 3 && rf_wr_data == 8'h5C, "write_regs_held", {rf_addr, rf_wr_data}, 12'h35C);
        idle(2);

        // read of register 7 with transmitter busy for 10 cycles
        put(8'hBB, 0); put(8'h07, 0); idle(2);
        tx_busy = 1; rf_rd_data = 8'hA5; rf_rd_valid = 1; step();
        idle(10);
        tx_busy = 0; idle(3);
        @(negedge clk);
        check(tx_data == 8'hA5, "tx_data_held", tx_data, 8'hA5);

        // bad command, then a flagged command byte
        put(8'h12, 0); idle(2);
        put(8'hAA, 1); idle(2);
        @(negedge clk);
        check(busy == 0, "idle_after_rx_err", busy, 0);

        // reset mid-frame: next byte is treated as a command
        put(8'hAA, 0); put(8'h03, 0);
        rst = 1; step();
        put(8'h5C, 0); idle(3);

        // silence after a write command
        put(8'hAA, 0); idle(TO + 4);
`ifdef SYS_CTRL_TIMEOUT_EN
        @(negedge clk);
        check(busy == 0, "busy_after_timeout", busy, 0);
`else
        idle(20);
        @(negedge clk);
        check(busy == 1, "busy_no_timeout", busy, 1);
`endif
        rst = 1; step(); idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 25) begin
                int k;
                k = $urandom_range(0, 9);
                rx_data = (k < 3) ? 8'hAA : (k < 6) ? 8'hBB : 8'($urandom);
                rx_valid = 1;
                rx_err = ($urandom_range(0, 15) == 0);
            end
            rf_rd_valid = ($urandom_range(0, 5) == 0);
            rf_rd_data  = 8'($urandom);
            tx_busy     = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 499) == 0) rst = 1;
            step();
        end
        rst = 1; tx_busy = 0; step(); idle(5);
        @(negedge clk);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        mon_en = 0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/sys_ctrl.md
SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, byte width of rx/tx/register data.
REQ-002 SHALL have parameter: ADDR_WIDTH, 4, register-file address width; uses the low ADDR_WIDTH bits of the address byte, upper bits ignored.
REQ-003 SHALL have parameter: TIMEOUT, 1023, idle cycles before a partial command is aborted; used only when the timeout feature is compiled in.
REQ-004 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port: rx_data  in  DATA_WIDTH  byte from UART receiver.
REQ-007 SHALL have port: rx_valid  in  1  one-cycle pulse, rx_data valid.
REQ-008 SHALL have port: rx_err  in  1  parity/stop error, qualified by rx_valid.
REQ-009 SHALL have port: rf_addr  out  ADDR_WIDTH  register-file address.
REQ-010 SHALL have port: rf_wr_en  out  1  one-cycle write strobe.
REQ-011 SHALL have port: rf_wr_data  out  DATA_WIDTH  write data.
REQ-012 SHALL have port: rf_rd_en  out  1  one-cycle read strobe.
REQ-013 SHALL have port: rf_rd_data  in  DATA_WIDTH  read data, qualified by rf_rd_valid.
REQ-014 SHALL have port: rf_rd_valid  in  1  read-data-valid pulse.
REQ-015 SHALL have port: tx_data  out  DATA_WIDTH  byte to UART transmitter.
REQ-016 SHALL have port: tx_valid  out  1  one-cycle transmit request.
REQ-017 SHALL have port: tx_busy  in  1  transmitter busy.
REQ-018 SHALL have port: cmd_err  out  1  one-cycle error pulse.
REQ-019 SHALL have port: busy  out  1  high in every state except IDLE.

Function
REQ-020 SHALL implement states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND; all outputs registered.
REQ-021 SHALL, in IDLE, on rx_valid with rx_data=0xAA go WR_ADDR, with 0xBB go RD_ADDR, with any other value stay IDLE and pulse cmd_err next cycle.
REQ-022 SHALL, in WR_ADDR on rx_valid, latch rf_addr and go WR_DATA.
REQ-023 SHALL, in WR_DATA on rx_valid, latch rf_wr_data, pulse rf_wr_en for exactly one cycle in the next cycle, and return to IDLE.
REQ-024 SHALL, in RD_ADDR on rx_valid, latch rf_addr, pulse rf_rd_en in the next cycle, and go RD_WAIT.
REQ-025 SHALL, in RD_WAIT on rf_rd_valid, latch rf_rd_data into tx_data and go TX_SEND; rf_rd_valid in any other state is ignored.
REQ-026 SHALL, in TX_SEND, pulse tx_valid for one cycle in the first cycle tx_busy is sampled low; tx_data is held stable from entry until that pulse; then go IDLE.
REQ-027 SHALL treat rx_valid with rx_err=1 in any state as a discarded byte: go IDLE, pulse cmd_err, no rf or tx strobe.
REQ-028 SHALL drop rx_valid bytes arriving in RD_WAIT or TX_SEND, pulse cmd_err, and continue the read in progress.
REQ-029 SHALL keep rf_addr, rf_wr_data and tx_data at their last values when not updated.
REQ-030 SHALL give rx_err/abort priority over rf_rd_valid when both occur in RD_WAIT in the same cycle.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, enter IDLE and clear rf_addr, rf_wr_data, tx_data, rf_wr_en, rf_rd_en, tx_valid, cmd_err, busy and the timeout counter, regardless of the current state.
REQ-032 SHALL produce no rf or tx strobe in the cycle after reset, including when reset aborts a command mid-frame.

Configuration
REQ-033 SHALL, with macro SYS_CTRL_TIMEOUT_EN defined, count cycles in WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT, reset the count on every accepted byte or rf_rd_valid, and on reaching TIMEOUT go IDLE and pulse cmd_err.
REQ-034 SHALL, without SYS_CTRL_TIMEOUT_EN, wait indefinitely in those states, contain no timeout counter, and leave TIMEOUT unused.

Verification
REQ-035 SHALL cover: bytes 0xAA,0x03,0x5C -> rf_wr_en high one cycle with rf_addr=3, rf_wr_data=0x5C; busy low afterwards.
REQ-036 SHALL cover: bytes 0xBB,0x07, rf_rd_valid with 0xA5, tx_busy=1 for 10 cycles -> tx_valid pulses once after tx_busy falls, tx_data=0xA5.
REQ-037 SHALL cover: byte 0x12 in IDLE -> cmd_err one cycle, no strobes; then 0xAA with rx_err=1 -> cmd_err, state IDLE.
REQ-038 SHALL cover: rst asserted after 0xAA,0x03 -> next byte 0x5C is handled as a command (cmd_err), no rf_wr_en.
REQ-039 SHALL cover, with SYS_CTRL_TIMEOUT_EN and TIMEOUT=16: 0xAA then silence -> cmd_err at cycle 16, busy low; without the macro, busy stays high.
